// File: rtl/eth_frame_encap_if.sv
// Bundles the payload-FIFO side and the GMII transmit side of the Ethernet II framer.
// Also carries the framer's current state for debug and checker binding.
interface eth_frame_encap_if #(
  parameter int WIDTH = 8
);
  // Handshake: buffer_ready is a level (frames queued, saturating at 3), sampled only
  // while the framer is idle. buf_r_en is a read strobe with no back-pressure: every
  // cycle it is high pops one byte, and that byte must be on data_in the next cycle.
  // gmii_tx_en qualifies gmii_txd; pct_txed is a single-cycle completion pulse.
  logic             eth_tx_en;
  logic [1:0]       buffer_ready;
  logic [WIDTH-1:0] data_in;
  logic             buf_r_en;
  logic [7:0]       gmii_txd;
  logic             gmii_tx_en;
  logic             pct_txed;
  logic [3:0]       dbg_state;

  modport master (
    output eth_tx_en, buffer_ready, data_in,
    input  buf_r_en, gmii_txd, gmii_tx_en, pct_txed, dbg_state
  );

  modport slave (
    input  eth_tx_en, buffer_ready, data_in,
    output buf_r_en, gmii_txd, gmii_tx_en, pct_txed, dbg_state
  );
endinterface

// File: rtl/eth_frame_encap.sv
// Ethernet II transmit framer: pulls a length-prefixed payload from the FIFO and emits
// preamble, SFD, MAC header, payload, zero padding and CRC-32 FCS on GMII.
module eth_frame_encap #(
  parameter logic [47:0] DEST_MAC    = 48'h40ac14dfbb66,
  parameter logic [47:0] SRC_MAC     = 48'he044e435dba6,
  parameter int          WIDTH       = 8,
  parameter int          MIN_PAYLOAD = 46,
  parameter int          MAX_PAYLOAD = 1500,
  parameter int          IFG_BYTES   = 12
) (
  input  logic             clk,
  input  logic             rst,
  eth_frame_encap_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN, S_PRE, S_SFD, S_DST, S_SRC,
    S_LTYPE, S_PAYLOAD, S_PAD, S_FCS, S_IFG
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] len_q, len_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  txd_q, txd_d;
  logic        tx_en_q, tx_en_d;
  logic        rd_q, rd_d;
  logic        pct_q, pct_d;

  logic [WIDTH-1:0] rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      raw_len;
  logic [10:0]      pad_last;
  logic [31:0]      fcs_word;
  logic [7:0]       tx_byte;

  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [47:0] sh;
    sh = mac << (8 * idx);
    return sh[47:40];
  endfunction

  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ b[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  assign rd_word  = bus.data_in;
  assign rd_byte  = rd_word[7:0];
  assign pad_last = 11'(MIN_PAYLOAD - 1) - len_q;

  // Next state, counters and the read strobe for the following cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 11'd1;
    len_d    = len_q;
    len_hi_d = len_hi_q;
    rd_d     = 1'b0;
    raw_len  = {len_hi_q, rd_byte};
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.eth_tx_en && (bus.buffer_ready != 2'd0)) begin
          state_d = S_LEN;
          rd_d    = 1'b1;
        end
      end
      S_LEN: begin
        if (cnt_q == 11'd0) rd_d = 1'b1;
        if (cnt_q == 11'd1) len_hi_d = rd_byte;
        if (cnt_q == 11'd2) begin
          len_d   = (raw_len > 16'(MAX_PAYLOAD)) ? 11'(MAX_PAYLOAD) : raw_len[10:0];
          state_d = S_PRE;
          cnt_d   = '0;
        end
      end
      S_PRE: if (cnt_q == 11'd6) begin state_d = S_SFD; cnt_d = '0; end
      S_SFD: begin state_d = S_DST; cnt_d = '0; end
      S_DST: if (cnt_q == 11'd5) begin state_d = S_SRC; cnt_d = '0; end
      S_SRC: if (cnt_q == 11'd5) begin state_d = S_LTYPE; cnt_d = '0; end
      S_LTYPE: begin
        // Reads run one cycle ahead of the wire, so the first fetch overlaps the length field.
        rd_d = (cnt_q == 11'd0) ? (len_q != 11'd0) : (len_q >= 11'd2);
        if (cnt_q == 11'd1) begin
          state_d = (len_q != 11'd0) ? S_PAYLOAD : S_PAD;
          cnt_d   = '0;
        end
      end
      S_PAYLOAD: begin
        rd_d = ({1'b0, cnt_q} + 12'd2) < {1'b0, len_q};
        if (cnt_q == len_q - 11'd1) begin
          state_d = (len_q < 11'(MIN_PAYLOAD)) ? S_PAD : S_FCS;
          cnt_d   = '0;
        end
      end
      S_PAD: if (cnt_q == pad_last) begin state_d = S_FCS; cnt_d = '0; end
      S_FCS: if (cnt_q == 11'd3) begin state_d = S_IFG; cnt_d = '0; end
      S_IFG: if (cnt_q == 11'(IFG_BYTES - 1)) begin state_d = S_IDLE; cnt_d = '0; end
      default: begin state_d = S_IDLE; cnt_d = '0; end
    endcase
  end

  // Fixed header bytes are prepared one cycle early so they leave from a register.
  always_comb begin
    txd_d = 8'h00;
    case (state_d)
      S_PRE:   txd_d = 8'h55;
      S_SFD:   txd_d = 8'hD5;
      S_DST:   txd_d = mac_byte(DEST_MAC, cnt_d[2:0]);
      S_SRC:   txd_d = mac_byte(SRC_MAC, cnt_d[2:0]);
      S_LTYPE: txd_d = cnt_d[0] ? len_d[7:0] : {5'b0, len_d[10:8]};
      default: txd_d = 8'h00;
    endcase
  end

  // Payload bytes pass straight from the FIFO so each read lands on the wire one cycle later.
  always_comb begin
    fcs_word = ~crc_q;
    case (state_q)
      S_PAYLOAD: tx_byte = rd_byte;
      S_FCS:     tx_byte = fcs_word[{cnt_q[1:0], 3'b000} +: 8];
      default:   tx_byte = txd_q;
    endcase
  end

  always_comb begin
    crc_d = crc_q;
    if (state_q == S_IDLE) begin
      crc_d = '1;
    end else if ((state_q == S_DST) || (state_q == S_SRC) || (state_q == S_LTYPE) ||
                 (state_q == S_PAYLOAD) || (state_q == S_PAD)) begin
      crc_d = crc_step(crc_q, tx_byte);
    end
  end

  assign tx_en_d = (state_d == S_PRE) || (state_d == S_SFD) || (state_d == S_DST) ||
                   (state_d == S_SRC) || (state_d == S_LTYPE) || (state_d == S_PAYLOAD) ||
                   (state_d == S_PAD) || (state_d == S_FCS);
  assign pct_d   = (state_q == S_FCS) && (cnt_q == 11'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      len_hi_q <= '0;
      crc_q    <= '1;
      txd_q    <= '0;
      tx_en_q  <= 1'b0;
      rd_q     <= 1'b0;
      pct_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      len_hi_q <= len_hi_d;
      crc_q    <= crc_d;
      txd_q    <= txd_d;
      tx_en_q  <= tx_en_d;
      rd_q     <= rd_d;
      pct_q    <= pct_d;
    end
  end

  assign bus.buf_r_en   = rd_q;
  assign bus.gmii_txd   = tx_byte;
  assign bus.gmii_tx_en = tx_en_q;
  assign bus.pct_txed   = pct_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_eth_frame_encap.sv
// Bench for eth_frame_encap: random payload frames checked byte-for-byte against a
// table-driven CRC-32 frame model, plus idle, back-to-back and mid-frame reset cases.
module tb_eth_frame_encap;

  localparam logic [47:0] DEST_MAC = 48'h40ac14dfbb66;
  localparam logic [47:0] SRC_MAC  = 48'he044e435dba6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eth_frame_encap_if #(.WIDTH(8)) bus ();

  eth_frame_encap dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  logic [7:0]  fifo_q[$];
  logic [7:0]  exp_q[$];
  int          exp_len_q[$];
  int          exp_rd_q[$];
  logic [7:0]  got_q[$];
  logic [31:0] crc_tab[256];

  int pending   = 0;
  int underflow = 0;
  int rd_cnt    = 0;
  int pct_cnt   = 0;
  int gap       = 0;
  bit prev_en   = 1'b0;
  bit have_prev = 1'b0;
  bit take      = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    checks_total++;
    if (got == exp) checks_passed++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic build_crc_tab();
    logic [31:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[i] = c;
    end
  endtask

  task automatic update_ready();
    bus.buffer_ready = (pending > 3) ? 2'd3 : 2'(pending);
  endtask

  // Upstream FIFO contents plus the complete expected wire image for one frame.
  task automatic queue_frame(input int len, input bit incr);
    logic [7:0]  body[$];
    logic [7:0]  b;
    logic [31:0] c;
    int          padn;
    fifo_q.push_back(8'(len >> 8));
    fifo_q.push_back(8'(len));
    for (int i = 0; i < 6; i++) body.push_back(8'(DEST_MAC >> (8 * (5 - i))));
    for (int i = 0; i < 6; i++) body.push_back(8'(SRC_MAC >> (8 * (5 - i))));
    body.push_back(8'(len >> 8));
    body.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      b = incr ? 8'(i) : 8'($urandom_range(0, 255));
      fifo_q.push_back(b);
      body.push_back(b);
    end
    padn = (len < 46) ? (46 - len) : 0;
    for (int i = 0; i < padn; i++) body.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (body[i]) c = crc_tab[c[7:0] ^ body[i]] ^ (c >> 8);
    c = ~c;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (body[i]) exp_q.push_back(body[i]);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(c >> (8 * i)));
    exp_len_q.push_back(8 + body.size() + 4);
    exp_rd_q.push_back(len + 2);
    pending++;
    update_ready();
  endtask

  task automatic end_frame();
    int         n, elen, erd, errs, fcs_errs;
    logic [7:0] e;
    n = got_q.size();
    if (exp_len_q.size() == 0) begin
      check("frame_expected", 0, 1);
    end else begin
      elen = exp_len_q.pop_front();
      erd  = exp_rd_q.pop_front();
      check("frame_len", n, elen);
      errs     = 0;
      fcs_errs = 0;
      for (int i = 0; i < elen; i++) begin
        e = exp_q.pop_front();
        if ((i >= n) || (got_q[i] !== e)) begin
          if (i >= elen - 4) fcs_errs++;
          else errs++;
        end
      end
      check("frame_bytes", errs, 0);
      check("frame_fcs", fcs_errs, 0);
      check("frame_reads", rd_cnt, erd);
    end
    got_q.delete();
    rd_cnt = 0;
    if (pending > 0) pending--;
    update_ready();
  endtask

  task automatic monitor();
    if (rst) begin
      got_q.delete();
      prev_en   = 1'b0;
      have_prev = 1'b0;
      gap       = 0;
      rd_cnt    = 0;
    end else begin
      if (bus.buf_r_en) rd_cnt++;
      if (bus.pct_txed) pct_cnt++;
      if (bus.gmii_tx_en) begin
        if (!prev_en && have_prev) check("ifg_gap_ge14", int'(gap >= 14), 1);
        if (bus.pct_txed) check("pct_during_frame", 1, 0);
        got_q.push_back(bus.gmii_txd);
        gap = 0;
      end else begin
        gap++;
        if (prev_en) begin
          check("pct_first_ifg", int'(bus.pct_txed), 1);
          end_frame();
          have_prev = 1'b1;
        end else if (bus.pct_txed) begin
          check("pct_stray", 1, 0);
        end
      end
      prev_en = bus.gmii_tx_en;
    end
  endtask

  // One clock: serve the FIFO read issued last cycle, then observe at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (take) begin
      if (fifo_q.size() > 0) bus.data_in = fifo_q.pop_front();
      else begin
        underflow++;
        bus.data_in = 8'h00;
      end
    end
    @(negedge clk);
    take = bus.buf_r_en;
    monitor();
  endtask

  task automatic wait_pct(input int target, input int budget);
    int n;
    n = 0;
    while ((pct_cnt < target) && (n < budget)) begin
      tick();
      n++;
    end
    check("frames_done", pct_cnt, target);
  endtask

  task automatic wait_tx_start(input int budget);
    int n;
    n = 0;
    while (!bus.gmii_tx_en && (n < budget)) begin
      tick();
      n++;
    end
    check("tx_started", int'(bus.gmii_tx_en), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int activity;
    int base;
    build_crc_tab();
    bus.eth_tx_en    = 1'b0;
    bus.buffer_ready = 2'd0;
    bus.data_in      = 8'h00;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_gmii_tx_en", int'(bus.gmii_tx_en), 0);
    check("rst_gmii_txd", int'(bus.gmii_txd), 0);
    check("rst_buf_r_en", int'(bus.buf_r_en), 0);
    check("rst_pct_txed", int'(bus.pct_txed), 0);

    bus.eth_tx_en = 1'b1;
    activity = 0;
    repeat (100) begin
      tick();
      if (bus.gmii_tx_en || bus.buf_r_en || bus.pct_txed) activity++;
    end
    check("idle_no_activity", activity, 0);

    queue_frame(46, 1'b1);
    wait_pct(1, 400);

    queue_frame(10, 1'b0);
    wait_tx_start(400);
    bus.eth_tx_en = 1'b0;
    wait_pct(2, 400);
    bus.eth_tx_en = 1'b1;

    queue_frame(1500, 1'b0);
    wait_pct(3, 2000);

    queue_frame(0, 1'b0);
    queue_frame($urandom_range(1, 60), 1'b0);
    wait_pct(5, 600);

    for (int i = 0; i < 6; i++) queue_frame($urandom_range(0, 300), 1'b0);
    wait_pct(11, 4000);

    queue_frame(200, 1'b0);
    wait_tx_start(400);
    repeat (30) tick();
    base = pct_cnt;
    rst = 1'b1;
    tick();
    check("rst_mid_gmii_tx_en", int'(bus.gmii_tx_en), 0);
    check("rst_mid_buf_r_en", int'(bus.buf_r_en), 0);
    fifo_q.delete();
    exp_q.delete();
    exp_len_q.delete();
    exp_rd_q.delete();
    pending = 0;
    update_ready();
    rst = 1'b0;
    repeat (60) tick();
    check("rst_mid_no_pct", pct_cnt, base);

    queue_frame(60, 1'b1);
    wait_pct(base + 1, 400);
    repeat (5) tick();
    check("fifo_underflow", underflow, 0);
    check("expected_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/eth_frame_encap.md
Name: eth_frame_encap

Overview:
- Single-clock Ethernet II transmit framer.
- When a payload frame is waiting in the upstream payload FIFO, it reads the frame's 2-byte length word and then the payload bytes.
- It emits a complete GMII byte stream: preamble, SFD, destination MAC, source MAC, length/type, payload, zero padding and CRC-32 FCS.
- It sits between the payload FIFO / frame-count tracker and the GMII TX pins, and reports each completed frame back to the tracker.

Parameters:
- DEST_MAC, 48'h40ac14dfbb66, destination MAC address; sent MSB byte first (0x40 first).
- SRC_MAC, 48'he044e435dba6, source MAC address; sent MSB byte first.
- WIDTH, 8, data byte width; only 8 is supported.
- MIN_PAYLOAD, 46, minimum payload bytes; shorter payloads are zero padded up to this.
- MAX_PAYLOAD, 1500, maximum payload bytes.
- IFG_BYTES, 12, idle cycles forced after each frame.

Ports:
- clk, input, 1, the single clock; all logic is rising-edge.
- rst, input, 1, synchronous active-high reset.
- eth_tx_en, input, 1, transmit enable; sampled only in IDLE.
- buffer_ready, input, 2, number of complete frames queued upstream, saturating at 3; nonzero means at least one frame is available.
- data_in, input, WIDTH, payload FIFO read data; valid the cycle after buf_r_en.
- buf_r_en, output, 1, payload FIFO read strobe; one byte per asserted cycle.
- gmii_txd, output, 8, transmit byte.
- gmii_tx_en, output, 1, high for every byte from the first preamble byte through the last FCS byte.
- pct_txed, output, 1, one-cycle pulse when a frame completes.

Behaviour:
- Reset values:
  - all outputs 0;
  - state IDLE;
  - CRC register 0xFFFFFFFF;
  - all counters 0.
- Reset mid-frame: outputs return to 0 on the next edge; the partial frame is abandoned and pct_txed is not pulsed.
- Upstream FIFO format, per frame: length high byte, length low byte, then exactly that many payload bytes.
- Read latency: a byte requested with buf_r_en in cycle t is captured from data_in in cycle t+1.
- Length clamping: L = min(length word, MAX_PAYLOAD). The clamped value is both the number of payload bytes read and the value sent in the length/type field. Upstream must not queue L > 1500.
- IDLE: if eth_tx_en=1 and buffer_ready!=0, go to LEN and assert buf_r_en this cycle.
- LEN: assert buf_r_en for the second length byte, then capture both length bytes (big-endian).
- PREAMBLE: 7 bytes of 0x55.
- SFD: 1 byte of 0xD5.
- DST: 6 bytes of DEST_MAC.
- SRC: 6 bytes of SRC_MAC.
- LENTYPE: 2 bytes of L, high byte first.
- PAYLOAD: L bytes.
  - buf_r_en is asserted exactly one cycle before each payload byte is output, so the stream has no bubbles.
  - Total buf_r_en pulses per frame = L + 2.
  - If L = 0, PAYLOAD is skipped.
- PAD: 0x00 for max(0, MIN_PAYLOAD − L) bytes.
- FCS: 4 bytes.
- IFG: IFG_BYTES cycles with gmii_tx_en=0, then return to IDLE.
- gmii_tx_en is continuously high from PREAMBLE through FCS.
- Frame length on the wire: 8 + 14 + max(L, 46) + 4 bytes.
- CRC-32 (IEEE 802.3):
  - reflected polynomial 0xEDB88320;
  - initial value 0xFFFFFFFF;
  - computed over DST through PAD inclusive;
  - bytes processed LSB first.
- FCS value: bitwise complement of the CRC register, sent least-significant byte first. It must equal the standard zlib crc32 of the same bytes.
- pct_txed pulses high for exactly one cycle, in the first IFG cycle.
- eth_tx_en deasserted mid-frame has no effect; the frame always completes.
- buffer_ready!=0 during IFG is ignored until IDLE is reached.
- Back-to-back frames: the next preamble starts at the earliest IDLE+LEN opportunity after IFG. The idle gap is at least IFG_BYTES + 2 cycles.

Test Plan:
- Reset, then hold eth_tx_en=1 with buffer_ready=0 for 100 cycles → gmii_tx_en=0, buf_r_en=0, pct_txed=0 throughout.
- Queue length 0x002E with 46 bytes 0x00..0x2D; set buffer_ready=1 and eth_tx_en=1 → the following are all required:
  - wire: gmii_tx_en high for exactly 72 cycles;
  - wire: bytes 55×7, D5, 40 AC 14 DF BB 66, E0 44 E4 35 DB A6, 00 2E, then the payload, then 4 FCS bytes matching zlib crc32 LSB first;
  - pct_txed: one pulse;
  - buf_r_en: 48 pulses.
- Length 0x000A with 10 payload bytes → the following are all required:
  - buf_r_en: 12 pulses;
  - length/type field: 00 0A;
  - padding: 36 bytes of 0x00;
  - wire: 72 bytes total, FCS correct.
- Length 1500 → 1526 bytes with gmii_tx_en continuously high, no bubble between payload bytes, and 1502 reads.
- Two frames queued (buffer_ready=2) → two frames separated by at least 14 idle cycles; two pct_txed pulses.
- Assert rst for one cycle during PAYLOAD → next cycle gmii_tx_en=0 and buf_r_en=0; no pct_txed; a new frame after reset transmits correctly.
